mult32_seq_ctrl: RTL and testbench

Iterative shift-add multiplier controller for the CPU datapath. It sequences one 32-bit adder pass per cycle over a product register pair to form a 64-bit HI:LO product. It also sequences two's-complement pre- and post-conversion for signed operation. It serves MULT/MULTU-style instructions and presents a START/BUSY/DONE handshake to the control unit.

---
 rtl/mult32_seq_ctrl_if.sv | 34 +++
 rtl/mult32_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mult32_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult32_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult32_seq_ctrl_if
// Handshake and operand/result bundle between the CPU control unit and the
// iterative multiplier.
//   START  : request, sampled by the multiplier only while idle
//   SIGNED : 1 = two's-complement operands, 0 = unsigned
//   A, B   : multiplicand / multiplier, captured together with START
//   BUSY   : multiplier is preparing, iterating or fixing up the sign
//   DONE   : one-cycle completion pulse
//   HI, LO : upper / lower word of the 2*WIDTH-bit product
// master = control unit side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface mult32_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, SIGNED, A, B,
        input  BUSY, DONE, HI, LO
    );

    modport slave (
        input  START, SIGNED, A, B,
        output BUSY, DONE, HI, LO
    );
endinterface

// File: rtl/mult32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult32_seq_ctrl
// Iterative shift-add multiplier for MULT/MULTU-style instructions. One adder
// pass per cycle over a {HI,LO} product register pair; signed operands are
// converted to magnitudes before the loop and the product is negated after it.
//
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RESET : asynchronous active-high reset, clears every register
//   bus   : slave side of mult32_seq_ctrl_if (START/SIGNED/A/B in,
//           BUSY/DONE/HI/LO out)
//
// Sequence: IDLE -> PREP (1) -> RUN (WIDTH) -> FIX (1) -> DONE (1) -> IDLE.
// HI/LO are only written in FIX, so partial products are never visible.
// -----------------------------------------------------------------------------
module mult32_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    mult32_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_shift;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_busy;
    logic               w_done;

    // Two's complement of an operand word.
    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Two's complement of the full product, modulo 2^(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] f_neg_p(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // Magnitude of an operand. The most-negative value maps onto itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no overflow case exists.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                               input logic               is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (is_signed && (sv < 0)) begin
            return f_neg_w(v);
        end
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Datapath combinational terms
    // ---------------------------------------------------------------------
    assign w_a_mag = f_mag(r_a, r_signed);
    assign w_b_mag = f_mag(r_b, r_signed);

    // Conditional add into the upper half keeps the carry so the shift that
    // follows brings it back into the product MSB.
    assign w_sum        = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                        + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod_shift = {w_sum, r_prod[WIDTH-1:1]};
    assign w_prod_fix   = r_neg ? f_neg_p(r_prod) : r_prod;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                w_busy = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Operand capture, iteration and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_signed <= bus.SIGNED;
                    end
                end
                S_PREP: begin
                    r_mcand <= w_a_mag;
                    r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                    r_neg   <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_cnt   <= CNT_W'(WIDTH);
                end
                S_RUN: begin
                    r_prod <= w_prod_shift;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.BUSY = w_busy;
    assign bus.DONE = w_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult32_seq_ctrl
// Self-checking bench for mult32_seq_ctrl: directed cases from the test plan
// plus randomized operands, compared against an arithmetic product model.
// -----------------------------------------------------------------------------
module tb_mult32_seq_ctrl;

    localparam int W = 32;
    localparam int BUSY_CYCLES = W + 2;   // PREP + RUN + FIX

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    mult32_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult32_seq_ctrl #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product: plain integer arithmetic on the operands.
    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One complete operation: request, timing, hold-during-run, result, pulse width.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input string tag);
        logic [63:0] exp;
        int          cyc;
        int          busy_n;
        exp = ref_mul(a, b, s);
        @(negedge clk);
        bus.START  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.SIGNED = s;
        @(negedge clk);
        bus.START  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.SIGNED = 1'($urandom_range(0, 1));
        cyc    = 0;
        busy_n = 0;
        while (cyc < 100) begin
            if (bus.DONE) break;
            if (bus.BUSY) busy_n++;
            if (cyc == 10) check({tag, ".hold"}, {bus.HI, bus.LO}, {prev_hi, prev_lo});
            cyc++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 64'(cyc), 64'(BUSY_CYCLES));
        check({tag, ".busy_cnt"}, 64'(busy_n), 64'(BUSY_CYCLES));
        check({tag, ".busy_in_done"}, 64'(bus.BUSY), 64'(0));
        check({tag, ".prod"}, {bus.HI, bus.LO}, exp);
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
        @(negedge clk);
        check({tag, ".done_width"}, 64'(bus.DONE), 64'(0));
    endtask

    initial begin
        int done_n;
        int busy_n;

        bus.START  = 1'b0;
        bus.SIGNED = 1'b0;
        bus.A      = '0;
        bus.B      = '0;

        // Reset state
        #1;
        check("rst.busy", 64'(bus.BUSY), 64'(0));
        check("rst.done", 64'(bus.DONE), 64'(0));
        check("rst.hilo", {bus.HI, bus.LO}, 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_mult(32'd3, 32'd5, 1'b0, "u3x5");
        check("u3x5.lit", {bus.HI, bus.LO}, 64'h0000_0000_0000_000F);
        do_mult(32'hFFFF_FFFD, 32'd5, 1'b1, "sm3x5");
        check("sm3x5.lit", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
        check("umax.lit", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "smax");
        check("smax.lit", {bus.HI, bus.LO}, 64'h0000_0000_0000_0001);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, "mneg2");
        check("mneg2.lit", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);
        do_mult(32'h8000_0000, 32'd1, 1'b1, "mneg1");
        check("mneg1.lit", {bus.HI, bus.LO}, 64'hFFFF_FFFF_8000_0000);
        do_mult(32'd0, 32'hFFFF_FFFF, 1'b1, "zero");
        check("zero.lit", {bus.HI, bus.LO}, 64'h0);

        // START while busy is ignored and operand changes have no effect
        @(negedge clk);
        bus.START = 1'b1; bus.A = 32'd7; bus.B = 32'd9; bus.SIGNED = 1'b0;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (9) @(negedge clk);
        bus.START = 1'b1; bus.A = 32'd2; bus.B = 32'd2;
        @(negedge clk);
        bus.START = 1'b0; bus.A = 32'd5; bus.B = 32'd11; bus.SIGNED = 1'b1;
        done_n = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.DONE) done_n++;
            @(negedge clk);
        end
        check("iso.done_pulses", 64'(done_n), 64'(1));
        check("iso.prod", {bus.HI, bus.LO}, 64'd63);
        prev_hi = '0;
        prev_lo = 32'd63;
        do_mult(32'd2, 32'd2, 1'b0, "iso.next");
        check("iso.next.lit", {bus.HI, bus.LO}, 64'd4);

        // Reset in the middle of an operation
        do_mult(32'd3, 32'd5, 1'b0, "pre_rst");
        @(negedge clk);
        bus.START = 1'b1; bus.A = 32'd6; bus.B = 32'd7; bus.SIGNED = 1'b0;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (19) @(negedge clk);
        check("mid.busy_before", 64'(bus.BUSY), 64'(1));
        rst = 1'b1;
        #1;
        check("mid.busy", 64'(bus.BUSY), 64'(0));
        check("mid.done", 64'(bus.DONE), 64'(0));
        check("mid.hilo", {bus.HI, bus.LO}, 64'h0);
        bus.START = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.rst_start_busy", 64'(bus.BUSY), 64'(0));
        bus.START = 1'b0;
        rst = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.DONE) done_n++;
            if (bus.BUSY) busy_n++;
            @(negedge clk);
        end
        check("mid.no_done", 64'(done_n), 64'(0));
        check("mid.idle", 64'(busy_n), 64'(0));
        prev_hi = '0;
        prev_lo = '0;
        do_mult(32'd6, 32'd7, 1'b0, "post_rst");
        check("post_rst.lit", {bus.HI, bus.LO}, 64'h2A);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            do_mult(pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
